vector_writeback: RTL and testbench

Result-side companion of the vector ALU in the RS5 vector unit. It sequences the per-register step counter that the ALU consumes and turns the ALU's result bus and mask-result bus into vector-register-file write requests. It handles register-group stepping for LMUL, doubled destination groups for widening, a single element-0 write for reductions and a single packed write for mask-producing compares. It sits between the ALU outputs and the VRF write port.

---
 rtl/vector_writeback.sv | 182 ++++++++++++++++++
 tb/tb_vector_writeback.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_writeback.sv
// Vector writeback: steps the LMUL group counter for the ALU and turns
// ALU results into VRF writes (normal, widening, reduction, mask).
package vector_writeback_pkg;
  typedef enum logic [2:0] {
    LMUL_1   = 3'b000,
    LMUL_2   = 3'b001,
    LMUL_4   = 3'b010,
    LMUL_8   = 3'b011,
    LMUL_1_8 = 3'b101,
    LMUL_1_4 = 3'b110,
    LMUL_1_2 = 3'b111
  } vlmul_e;
endpackage

module vector_writeback
  import vector_writeback_pkg::*;
#(
  parameter int VLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic [4:0]      vd_i,
  input  vlmul_e          vlmul_i,
  input  logic            widening_i,
  input  logic            reduction_i,
  input  logic            mask_dest_i,
  input  logic            alu_hold_i,
  input  logic [VLEN-1:0] result_i,
  input  logic [VLEN-1:0] result_mask_i,
  output logic [3:0]      cycle_count_o,
  output logic [3:0]      cycle_count_r_o,
  output logic            we_o,
  output logic [4:0]      waddr_o,
  output logic [VLEN-1:0] wdata_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            error_o
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DRAIN,
    COMMIT
  } state_e;

  state_e     state_q;
  logic [4:0] vd_q;
  logic       wide_q;
  logic       red_q;
  logic       mask_q;
  logic [2:0] last_q;
  logic [2:0] cnt_q;
  logic [2:0] cnt_r_q;
  logic       we_q;
  logic [4:0] waddr_q;
  logic       sel_mask_q;
  logic       done_q;
  logic       error_q;

  logic [2:0] last_d;
  logic       normal;
  logic       in_exec;
  logic       last_step;
  logic [4:0] a_lo;
  logic [4:0] a_hi;
  logic [4:0] a_n;
  logic       wr_d;
  logic [4:0] wa_d;

  always_comb begin
    last_d = 3'd0;
    unique case (vlmul_i)
      LMUL_2:  last_d = 3'd1;
      LMUL_4:  last_d = 3'd3;
      LMUL_8:  last_d = 3'd7;
      default: last_d = 3'd0;
    endcase
  end

  assign normal    = !red_q && !mask_q;
  assign in_exec   = state_q == EXEC;
  assign last_step = in_exec && !alu_hold_i && cnt_q == last_q;
  assign a_lo      = vd_q + {1'b0, cnt_q, 1'b0};
  assign a_hi      = a_lo + 5'd1;
  assign a_n       = vd_q + {2'b00, cnt_q};

  // Widening splits each step: held cycle = low half, completing = high.
  always_comb begin
    wr_d = 1'b0;
    wa_d = vd_q;
    unique case (1'b1)
      in_exec && normal && !alu_hold_i: begin
        wr_d = 1'b1;
        wa_d = wide_q ? a_hi : a_n;
      end
      in_exec && normal && alu_hold_i && wide_q: begin
        wr_d = 1'b1;
        wa_d = a_lo;
      end
      last_step && red_q: wr_d = 1'b1;
      state_q == DRAIN && mask_q: wr_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      vd_q       <= '0;
      wide_q     <= 1'b0;
      red_q      <= 1'b0;
      mask_q     <= 1'b0;
      last_q     <= '0;
      cnt_q      <= '0;
      cnt_r_q    <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      sel_mask_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      we_q       <= wr_d;
      waddr_q    <= wa_d;
      sel_mask_q <= state_q == DRAIN && mask_q;
      cnt_r_q    <= cnt_q;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (widening_i && vlmul_i == LMUL_8) begin
              error_q <= 1'b1;
            end else begin
              vd_q    <= vd_i;
              wide_q  <= widening_i;
              red_q   <= reduction_i;
              mask_q  <= mask_dest_i;
              last_q  <= last_d;
              cnt_q   <= '0;
              state_q <= EXEC;
            end
          end
        end
        EXEC: begin
          if (!alu_hold_i) begin
            if (cnt_q == last_q) begin
              state_q <= DRAIN;
              done_q  <= !mask_q;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        DRAIN: begin
          if (mask_q) begin
            state_q <= COMMIT;
            done_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end
        end
        COMMIT: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign cycle_count_o   = {1'b0, cnt_q};
  assign cycle_count_r_o = {1'b0, cnt_r_q};
  assign we_o            = we_q;
  assign waddr_o         = waddr_q;
  assign wdata_o         = sel_mask_q ? result_mask_i : result_i;
  assign busy_o          = state_q != IDLE;
  assign done_o          = done_q;
  assign error_o         = error_q;

endmodule

// File: tb/tb_vector_writeback.sv
// Randomized bench for vector_writeback against a per-cycle
// expectation table built from the step/write rules.
module tb_vector_writeback;
  import vector_writeback_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [4:0]  vd_i;
  vlmul_e      vlmul_i;
  logic        widening_i;
  logic        reduction_i;
  logic        mask_dest_i;
  logic        alu_hold_i;
  logic [63:0] result_i;
  logic [63:0] result_mask_i;
  logic [3:0]  cycle_count_o;
  logic [3:0]  cycle_count_r_o;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [63:0] wdata_o;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  vector_writeback #(.VLEN(64)) dut (
    .clk             (clk),
    .reset           (reset),
    .start_i         (start_i),
    .vd_i            (vd_i),
    .vlmul_i         (vlmul_i),
    .widening_i      (widening_i),
    .reduction_i     (reduction_i),
    .mask_dest_i     (mask_dest_i),
    .alu_hold_i      (alu_hold_i),
    .result_i        (result_i),
    .result_mask_i   (result_mask_i),
    .cycle_count_o   (cycle_count_o),
    .cycle_count_r_o (cycle_count_r_o),
    .we_o            (we_o),
    .waddr_o         (waddr_o),
    .wdata_o         (wdata_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .error_o         (error_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit pend_err = 1'b0;

  vlmul_e lm_tab [7] = '{LMUL_1, LMUL_2, LMUL_4, LMUL_8,
                         LMUL_1_8, LMUL_1_4, LMUL_1_2};

  bit         e_we   [64];
  logic [4:0] e_ad   [64];
  bit         e_mk   [64];
  int         e_cc   [64];
  bit         e_hold [64];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic idle_check(input string tag);
    chk({tag, "_busy"}, 64'(busy_o), 64'(0));
    chk({tag, "_we"}, 64'(we_o), 64'(0));
    chk({tag, "_done"}, 64'(done_o), 64'(0));
    chk({tag, "_err"}, 64'(error_o), 64'(pend_err));
    pend_err = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
    start_i = 1'b0;
    alu_hold_i = 1'($urandom);
    result_i = rnd64();
    @(negedge clk);
    idle_check("idle");
  endtask

  task automatic run_instr(input logic [4:0] vd, input vlmul_e lm,
                           input bit wd, input bit rd, input bit mk,
                           input int hmin, input int hmax);
    int n, k, drain, last, h;
    logic [63:0] exp_d;
    case (lm)
      LMUL_2:  n = 2;
      LMUL_4:  n = 4;
      LMUL_8:  n = 8;
      default: n = 1;
    endcase
    foreach (e_we[i]) begin
      e_we[i] = 0; e_ad[i] = '0; e_mk[i] = 0;
      e_cc[i] = 0; e_hold[i] = 0;
    end
    k = 1;
    for (int c = 0; c < n; c++) begin
      h = hmin + int'($urandom % 32'(hmax - hmin + 1));
      for (int j = 0; j < h; j++) begin
        e_hold[k] = 1; e_cc[k] = c;
        if (wd && !rd && !mk) begin
          e_we[k+1] = 1; e_ad[k+1] = 5'(int'(vd) + 2 * c);
        end
        k++;
      end
      e_hold[k] = 0; e_cc[k] = c;
      if (!rd && !mk) begin
        e_we[k+1] = 1;
        e_ad[k+1] = wd ? 5'(int'(vd) + 2 * c + 1) : 5'(int'(vd) + c);
      end
      k++;
    end
    drain = k;
    e_cc[drain] = n - 1;
    if (rd) begin e_we[drain] = 1; e_ad[drain] = vd; end
    last = drain;
    if (mk) begin
      last = drain + 1;
      e_we[last] = 1; e_ad[last] = vd; e_mk[last] = 1;
    end

    @(posedge clk); #1;
    start_i = 1'b1; vd_i = vd; vlmul_i = lm;
    widening_i = wd; reduction_i = rd; mask_dest_i = mk;
    alu_hold_i = 1'($urandom);
    result_i = rnd64(); result_mask_i = rnd64();
    @(negedge clk);
    idle_check("start");
    if (wd && n == 8) begin
      pend_err = 1'b1;
      return;
    end

    for (int t = 1; t <= last; t++) begin
      @(posedge clk); #1;
      start_i = ($urandom % 4) == 0;
      vd_i = 5'($urandom);
      vlmul_i = lm_tab[$urandom % 7];
      widening_i = 1'($urandom);
      reduction_i = 1'($urandom);
      mask_dest_i = 1'($urandom);
      alu_hold_i = (t < drain) ? e_hold[t] : 1'($urandom);
      result_i = rnd64(); result_mask_i = rnd64();
      @(negedge clk);
      chk("busy", 64'(busy_o), 64'(1));
      chk("we", 64'(we_o), 64'(e_we[t]));
      if (e_we[t]) begin
        exp_d = e_mk[t] ? result_mask_i : result_i;
        chk("waddr", 64'(waddr_o), 64'(e_ad[t]));
        chk("wdata", wdata_o, exp_d);
      end
      chk("done", 64'(done_o), 64'(t == last));
      chk("error", 64'(error_o), 64'(0));
      if (t <= drain) chk("cc", 64'(cycle_count_o), 64'(e_cc[t]));
      if (t >= 2 && t <= drain)
        chk("cc_r", 64'(cycle_count_r_o), 64'(e_cc[t-1]));
    end
  endtask

  task automatic mid_reset();
    @(posedge clk); #1;
    start_i = 1'b1; vd_i = 5'd2; vlmul_i = LMUL_4;
    widening_i = 0; reduction_i = 0; mask_dest_i = 0; alu_hold_i = 0;
    @(negedge clk);
    idle_check("rst_start");
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
      start_i = 1'b0; alu_hold_i = 1'b0; result_i = rnd64();
      @(negedge clk);
      chk("rst_cc", 64'(cycle_count_o), 64'(k - 1));
    end
    chk("rst_we_pre", 64'(we_o), 64'(1));
    chk("rst_ad_pre", 64'(waddr_o), 64'(3));
    reset = 1'b1;
    #1;
    chk("rst_cc0", 64'(cycle_count_o), 64'(0));
    chk("rst_ccr0", 64'(cycle_count_r_o), 64'(0));
    chk("rst_we0", 64'(we_o), 64'(0));
    chk("rst_ad0", 64'(waddr_o), 64'(0));
    chk("rst_busy0", 64'(busy_o), 64'(0));
    chk("rst_done0", 64'(done_o), 64'(0));
    chk("rst_err0", 64'(error_o), 64'(0));
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      alu_hold_i = 1'($urandom);
      @(negedge clk);
      chk("post_rst_we", 64'(we_o), 64'(0));
      chk("post_rst_busy", 64'(busy_o), 64'(0));
    end
  endtask

  initial begin
    int kind;
    vlmul_e lm;
    reset = 1'b1; start_i = 0; vd_i = 0; vlmul_i = LMUL_1;
    widening_i = 0; reduction_i = 0; mask_dest_i = 0;
    alu_hold_i = 0; result_i = 0; result_mask_i = 0;
    repeat (2) @(negedge clk);
    chk("rst_cc", 64'(cycle_count_o), 64'(0));
    chk("rst_ccr", 64'(cycle_count_r_o), 64'(0));
    chk("rst_we", 64'(we_o), 64'(0));
    chk("rst_waddr", 64'(waddr_o), 64'(0));
    chk("rst_busy", 64'(busy_o), 64'(0));
    chk("rst_done", 64'(done_o), 64'(0));
    chk("rst_err", 64'(error_o), 64'(0));
    reset = 1'b0;

    run_instr(5'd8, LMUL_4, 0, 0, 0, 0, 0);
    run_instr(5'd4, LMUL_2, 1, 0, 0, 1, 1);
    run_instr(5'd12, LMUL_2, 0, 1, 0, 2, 2);
    run_instr(5'd0, LMUL_8, 0, 0, 1, 0, 0);
    run_instr(5'd31, LMUL_2, 0, 0, 0, 0, 0);
    run_instr(5'd30, LMUL_4, 1, 0, 0, 0, 2);
    run_instr(5'd3, LMUL_8, 1, 0, 0, 0, 0);
    run_instr(5'd30, LMUL_4, 0, 0, 0, 0, 1);

    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom % 4);
      lm = lm_tab[$urandom % 7];
      run_instr(5'($urandom), lm, kind == 1, kind == 2, kind == 3,
                0, 2);
    end

    idle_cycle();
    mid_reset();
    run_instr(5'd7, LMUL_8, 1, 0, 0, 0, 1);
    run_instr(5'd9, LMUL_8, 0, 1, 0, 0, 1);
    idle_cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
